// File: rtl/rsa_exp_sequencer_if.sv
// Control/handshake bundle between a host and the MMM exponentiation sequencer.
// The master drives the request side; the slave (the sequencer) drives status and datapath controls.
interface rsa_exp_sequencer_if #(
    parameter int EXP_WIDTH = 10,
    parameter int LEN_W     = $clog2(EXP_WIDTH + 1)
);
    logic                 en;
    logic                 start;
    logic                 abort;
    logic [EXP_WIDTH-1:0] exp_e;
    logic [LEN_W-1:0]     exp_len;

    logic                 busy;
    logic                 done;
    logic                 eoc;
    logic                 rst_mmm;
    logic                 ld_a;
    logic                 ld_r;
    logic                 lock1;
    logic                 lock2;
    logic [1:0]           sel1;
    logic                 sel2;

    modport master (
        output en, start, abort, exp_e, exp_len,
        input  busy, done, eoc, rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2
    );

    modport slave (
        input  en, start, abort, exp_e, exp_len,
        output busy, done, eoc, rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2
    );
endinterface

// File: rtl/rsa_exp_sequencer.sv
// Purpose: FSM sequencing the Montgomery-multiplier datapath through PRE, per-bit EXP and POST slots.
// Latency: done pulses 1+(2+len)*(WIDTH+4) enabled cycles after start is accepted.
// Backpressure: en=0 freezes all state and outputs; start is only taken in IDLE with en=1.
module rsa_exp_sequencer #(
    parameter  int WIDTH     = 8,
    parameter  int EXP_WIDTH = 10,
    localparam int LEN_W     = $clog2(EXP_WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    rsa_exp_sequencer_if.slave bus
);

    localparam int S    = WIDTH + 4;
    localparam int SC_W = $clog2(S);

    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(S - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(EXP_WIDTH);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_EXP  = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]           state;
    logic [SC_W-1:0]      sc;
    logic [LEN_W-1:0]     bc;
    logic [LEN_W-1:0]     len_reg;
    logic [EXP_WIDTH-1:0] e_reg;
    logic                 eoc_r;
    logic                 slot_end;

    assign slot_end = (sc == SC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sc      <= '0;
            bc      <= '0;
            len_reg <= '0;
            e_reg   <= '0;
            eoc_r   <= 1'b0;
        end else if (bus.en) begin
            if (state != ST_IDLE && bus.abort) begin
                // eoc was cleared when this run was accepted, so an aborted run never raises it
                state <= ST_IDLE;
                sc    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            e_reg   <= bus.exp_e;
                            len_reg <= (bus.exp_len > LEN_MAX) ? LEN_MAX : bus.exp_len;
                            bc      <= '0;
                            eoc_r   <= 1'b0;
                            sc      <= '0;
                            state   <= ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (slot_end) begin
                            sc    <= '0;
                            state <= (len_reg != '0) ? ST_EXP : ST_POST;
                        end else begin
                            sc <= sc + SC_W'(1);
                        end
                    end
                    ST_EXP: begin
                        if (slot_end) begin
                            sc    <= '0;
                            e_reg <= e_reg >> 1;
                            bc    <= bc + LEN_W'(1);
                            if (bc == len_reg - LEN_W'(1)) begin
                                state <= ST_POST;
                            end
                        end else begin
                            sc <= sc + SC_W'(1);
                        end
                    end
                    ST_POST: begin
                        if (slot_end) begin
                            // eoc rises together with the single DONE cycle
                            sc    <= '0;
                            eoc_r <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            sc <= sc + SC_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        sc    <= '0;
                    end
                endcase
            end
        end
    end

    logic       busy_c;
    logic       done_c;
    logic       rst_mmm_c;
    logic       ld_a_c;
    logic       ld_r_c;
    logic       lock1_c;
    logic       lock2_c;
    logic [1:0] sel1_c;
    logic       sel2_c;

    always_comb begin
        busy_c    = 1'b0;
        done_c    = 1'b0;
        rst_mmm_c = 1'b0;
        ld_a_c    = 1'b0;
        ld_r_c    = 1'b0;
        lock1_c   = 1'b0;
        lock2_c   = 1'b0;
        sel1_c    = 2'b00;
        sel2_c    = 1'b0;
        case (state)
            ST_PRE: begin
                busy_c    = 1'b1;
                rst_mmm_c = 1'b1;
                ld_a_c    = (sc == '0);
                ld_r_c    = slot_end;
                lock1_c   = 1'b1;
                lock2_c   = 1'b1;
            end
            ST_EXP: begin
                // Square every slot; multiply into result 1 only where the current exponent bit is set
                busy_c    = 1'b1;
                rst_mmm_c = 1'b1;
                ld_a_c    = (sc == '0);
                ld_r_c    = slot_end;
                lock1_c   = e_reg[0];
                lock2_c   = 1'b1;
                sel1_c    = 2'b01;
                sel2_c    = 1'b1;
            end
            ST_POST: begin
                busy_c    = 1'b1;
                rst_mmm_c = 1'b1;
                ld_a_c    = (sc == '0);
                ld_r_c    = slot_end;
                lock1_c   = 1'b1;
                sel1_c    = 2'b10;
                sel2_c    = 1'b1;
            end
            ST_DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                rst_mmm_c = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
            end
        endcase
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.eoc     = eoc_r;
    assign bus.rst_mmm = rst_mmm_c;
    assign bus.ld_a    = ld_a_c;
    assign bus.ld_r    = ld_r_c;
    assign bus.lock1   = lock1_c;
    assign bus.lock2   = lock2_c;
    assign bus.sel1    = sel1_c;
    assign bus.sel2    = sel2_c;

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Bench for rsa_exp_sequencer: two parameterisations, directed vector table, corner sequences and
// randomized traffic, all checked cycle by cycle against a slot-arithmetic reference model.
module tb_rsa_exp_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        tb_en, tb_start, tb_abort;
    logic [16:0] tb_e;
    logic [4:0]  tb_len;

    rsa_exp_sequencer_if #(.EXP_WIDTH(10)) bus_a ();
    rsa_exp_sequencer_if #(.EXP_WIDTH(17)) bus_b ();

    assign bus_a.en      = tb_en;
    assign bus_a.start   = tb_start;
    assign bus_a.abort   = tb_abort;
    assign bus_a.exp_e   = tb_e[9:0];
    assign bus_a.exp_len = tb_len[3:0];
    assign bus_b.en      = tb_en;
    assign bus_b.start   = tb_start;
    assign bus_b.abort   = tb_abort;
    assign bus_b.exp_e   = tb_e;
    assign bus_b.exp_len = tb_len;

    rsa_exp_sequencer #(.WIDTH(8), .EXP_WIDTH(10)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    rsa_exp_sequencer #(.WIDTH(16), .EXP_WIDTH(17)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       eoc;
        logic       rst_mmm;
        logic       ld_a;
        logic       ld_r;
        logic       lock1;
        logic       lock2;
        logic [1:0] sel1;
        logic       sel2;
    } out_t;

    typedef struct {
        int          dut;
        logic [16:0] e;
        int          len;
        int          stall_at;
        int          stall_n;
        int          abort_at;
        int          start2_at;
        int          exp_done;
        int          exp_sel01;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    string tag    = "init";

    int which  = 0;
    int S_cur  = 12;
    int ew_cur = 10;

    // Reference model: progress count k of enabled cycles since acceptance, decoded by slot arithmetic
    bit          m_active = 1'b0;
    bit          m_eoc    = 1'b0;
    int          m_k, m_len, m_total;
    logic [16:0] m_e;

    function automatic out_t dut_out();
        out_t o;
        if (which == 0)
            o = {bus_a.busy, bus_a.done, bus_a.eoc, bus_a.rst_mmm, bus_a.ld_a, bus_a.ld_r,
                 bus_a.lock1, bus_a.lock2, bus_a.sel1, bus_a.sel2};
        else
            o = {bus_b.busy, bus_b.done, bus_b.eoc, bus_b.rst_mmm, bus_b.ld_a, bus_b.ld_r,
                 bus_b.lock1, bus_b.lock2, bus_b.sel1, bus_b.sel2};
        return o;
    endfunction

    function automatic out_t model_out();
        out_t o;
        int   slot, pos;
        o     = '0;
        o.eoc = m_eoc;
        if (m_active) begin
            o.busy    = 1'b1;
            o.rst_mmm = 1'b1;
            if (m_k == m_total) begin
                o.done = 1'b1;
            end else begin
                slot   = (m_k - 1) / S_cur;
                pos    = (m_k - 1) % S_cur;
                o.ld_a = (pos == 0);
                o.ld_r = (pos == S_cur - 1);
                if (slot == 0) begin
                    o.lock1 = 1'b1;
                    o.lock2 = 1'b1;
                end else if (slot <= m_len) begin
                    o.lock1 = m_e[slot-1];
                    o.lock2 = 1'b1;
                    o.sel1  = 2'b01;
                    o.sel2  = 1'b1;
                end else begin
                    o.lock1 = 1'b1;
                    o.sel1  = 2'b10;
                    o.sel2  = 1'b1;
                end
            end
        end
        return o;
    endfunction

    task automatic model_clock();
        logic rs;
        int   len_in;
        rs     = (which == 0) ? rst_a : rst_b;
        len_in = (which == 0) ? int'(tb_len[3:0]) : int'(tb_len);
        if (rs) begin
            m_active = 1'b0;
            m_eoc    = 1'b0;
        end else if (tb_en) begin
            if (!m_active) begin
                if (tb_start && !tb_abort) begin
                    m_active = 1'b1;
                    m_k      = 1;
                    m_len    = (len_in > ew_cur) ? ew_cur : len_in;
                    m_total  = 1 + (m_len + 2) * S_cur;
                    m_e      = (which == 0) ? {7'b0, tb_e[9:0]} : tb_e;
                    m_eoc    = 1'b0;
                end
            end else if (tb_abort || m_k == m_total) begin
                m_active = 1'b0;
            end else begin
                m_k = m_k + 1;
                if (m_k == m_total) m_eoc = 1'b1;
            end
        end
    endtask

    task automatic tick(output logic dn, output logic s01);
        out_t a, e;
        a = dut_out();
        e = model_out();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc %0d: busy,done,eoc,rst_mmm,ld_a,ld_r,lock1,lock2,sel1,sel2 got %b want %b",
                     tag, cyc, a, e);
        end
        dn  = a.done;
        s01 = (a.sel1 == 2'b01);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic select_dut(input int w);
        if (w != which) begin
            m_active = 1'b0;
            m_eoc    = 1'b0;
        end
        which  = w;
        S_cur  = (w == 0) ? 12 : 20;
        ew_cur = (w == 0) ? 10 : 17;
        if (w == 0) rst_b = 1'b1;
        else        rst_a = 1'b1;
    endtask

    task automatic do_reset();
        logic d, s;
        tb_start = 1'b0;
        tb_abort = 1'b0;
        tb_en    = 1'b1;
        if (which == 0) rst_a = 1'b1; else rst_b = 1'b1;
        tick(d, s);
        tick(d, s);
        if (which == 0) rst_a = 1'b0; else rst_b = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic d, s;
        int   done_at, sel01;
        select_dut(v.dut);
        $sformat(tag, "vec%0d", idx);
        do_reset();
        tb_e    = v.e;
        tb_len  = 5'(v.len);
        done_at = -1;
        sel01   = 0;
        cyc     = 0;
        for (int c = 0; c < 1000 && done_at < 0; c++) begin
            tb_start = (c == 0) || (c == v.start2_at);
            tb_abort = (c == v.abort_at);
            tb_en    = !(c >= v.stall_at && c < v.stall_at + v.stall_n);
            tick(d, s);
            if (s) sel01++;
            if (d) done_at = c;
        end
        tb_start = 1'b0;
        tb_abort = 1'b0;
        tb_en    = 1'b1;
        check_eq({tag, "_done_cycle"}, done_at, v.exp_done);
        check_eq({tag, "_sel01_cycles"}, sel01, v.exp_sel01);
        tick(d, s);
        check_eq({tag, "_eoc_after"}, int'(dut_out().eoc), 1);
        tick(d, s);
    endtask

    vec_t vecs[8];

    initial begin
        logic d, s;
        out_t o;
        tb_en = 1'b1; tb_start = 1'b0; tb_abort = 1'b0; tb_e = '0; tb_len = '0;
        rst_a = 1'b1; rst_b = 1'b1;

        //          dut e          len stall   n abort start2 done sel01
        vecs[0] = '{0, 17'h0000B,  4,  -1,    0, -1,   -1,    73,  48};
        vecs[1] = '{0, 17'h0000B,  4,  30,    5, -1,   -1,    78,  53};
        vecs[2] = '{0, 17'h0000B,  4,  -1,    0, 30,   40,   113,  66};
        vecs[3] = '{0, 17'h003FF,  0,  -1,    0, -1,   -1,    25,   0};
        vecs[4] = '{0, 17'h002A5, 15,  -1,    0, -1,   -1,   145, 120};
        vecs[5] = '{0, 17'h00136, 10,  -1,    0, -1,   -1,   145, 120};
        vecs[6] = '{1, 17'h1ABCD, 17,  -1,    0, -1,  100,   381, 340};
        vecs[7] = '{1, 17'h0F0F1, 31,  -1,    0, -1,   -1,   381, 340};

        @(negedge clk);
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of the EXP phase
        select_dut(0);
        tag = "rst_mid";
        do_reset();
        tb_e = 17'h0000B; tb_len = 5'd4;
        tb_start = 1'b1; tick(d, s); tb_start = 1'b0;
        repeat (20) tick(d, s);
        check_eq("rst_mid_busy_before", int'(dut_out().busy), 1);
        rst_a = 1'b1; tick(d, s); tick(d, s); rst_a = 1'b0;
        o = dut_out();
        check_eq("rst_mid_outputs", int'(o), 0);
        tick(d, s);

        // start together with abort in IDLE is ignored and leaves eoc untouched
        tag = "idle_abort";
        tb_start = 1'b1; tick(d, s); tb_start = 1'b0;
        repeat (80) tick(d, s);
        tb_start = 1'b1; tb_abort = 1'b1; tick(d, s);
        tb_start = 1'b0; tb_abort = 1'b0;
        o = dut_out();
        check_eq("idle_abort_busy", int'(o.busy), 0);
        check_eq("idle_abort_eoc", int'(o.eoc), 1);

        // start with en=0 is ignored; a later enabled start is taken and clears eoc
        tag = "idle_en0";
        tb_en = 1'b0; tb_start = 1'b1; tick(d, s);
        tb_en = 1'b1; tb_start = 1'b0;
        check_eq("en0_start_busy", int'(dut_out().busy), 0);
        tb_start = 1'b1; tick(d, s); tb_start = 1'b0;
        o = dut_out();
        check_eq("start_taken_busy", int'(o.busy), 1);
        check_eq("start_taken_eoc", int'(o.eoc), 0);
        check_eq("start_taken_ld_a", int'(o.ld_a), 1);
        repeat (3) tick(d, s);

        // Randomized traffic: stalls, aborts, stray starts and changing operands
        for (int it = 0; it < 20; it++) begin
            select_dut(it % 2);
            $sformat(tag, "rand%0d", it);
            do_reset();
            for (int c = 0; c < 500; c++) begin
                tb_e     = 17'($urandom);
                tb_len   = 5'($urandom_range(0, (it % 2) ? 31 : 15));
                tb_en    = ($urandom_range(0, 9) != 0);
                tb_start = (c == 0) || ($urandom_range(0, 59) == 0);
                tb_abort = ($urandom_range(0, 399) == 0);
                tick(d, s);
            end
            tb_start = 1'b0; tb_abort = 1'b0; tb_en = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_exp_sequencer.md
Name: rsa_exp_sequencer

Overview:
- Parametrised control sequencer for the Montgomery-multiplier (MMM) modular-exponentiation datapath.
- Drives the same datapath control set as the existing fixed 8-bit/10-bit control unit: rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, eoc.
- Generalised in operand width and exponent width.
- Replaces the free-running counter with an explicit FSM.
- Adds a start/busy/done handshake, runtime exponent length, abort, and clock-enable stall.

Parameters:
- WIDTH, 8, MMM operand width in bits; one MMM slot lasts S = WIDTH+4 cycles.
- EXP_WIDTH, 10, maximum exponent width in bits.
- LEN_W, $clog2(EXP_WIDTH+1), width of exp_len; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- en  in  1  clock enable; 0 freezes all state and outputs.
- start  in  1  request; sampled only in IDLE with en=1.
- abort  in  1  synchronous abort; highest priority after rst.
- exp_e  in  EXP_WIDTH  exponent, LSB processed first; captured on start.
- exp_len  in  LEN_W  number of exponent bits to process; captured on start.
- busy  out  1  high in PRE/EXP/POST/DONE.
- done  out  1  one-cycle pulse in DONE.
- eoc  out  1  sticky end-of-computation.
- rst_mmm  out  1  active-low MMM datapath clear.
- ld_a  out  1  MMM operand load.
- ld_r  out  1  MMM result capture.
- lock1  out  1  result-register-1 update enable.
- lock2  out  1  result-register-2 update enable.
- sel1  out  2  MMM operand-A mux select.
- sel2  out  1  MMM operand-B mux select.

Behaviour:
- States: IDLE, PRE, EXP, POST, DONE.
- Sub-counter sc runs 0..S-1 inside PRE, EXP and POST.
  - sc=0: ld_a=1.
  - sc=1..WIDTH+2: compute; ld_a=0, ld_r=0.
  - sc=S-1: ld_r=1.
- Outputs are Moore-decoded from the registered state/sc; no combinational path from inputs.
- Reset / IDLE: all outputs 0, including rst_mmm=0 (datapath held cleared). eoc keeps its value in IDLE; rst clears it.
- IDLE → PRE when start=1, en=1, abort=0:
  - Capture e_reg=exp_e.
  - Capture len_reg=min(exp_len, EXP_WIDTH).
  - Clear bit counter bc and eoc.
  - PRE begins next cycle at sc=0.
- PRE (Montgomery-domain conversion): rst_mmm=1, lock1=1, lock2=1, sel1=00, sel2=0.
  - At sc=S-1: go to EXP if len_reg≠0, else to POST.
- EXP (one slot per exponent bit): rst_mmm=1, lock1=e_reg[0], lock2=1, sel1=01, sel2=1.
  - At sc=S-1: e_reg shifts right by 1 and bc increments.
  - When bc reaches len_reg-1 at sc=S-1: go to POST; otherwise start the next slot.
- POST (conversion out of Montgomery domain): rst_mmm=1, lock1=1, lock2=0, sel1=10, sel2=1.
  - At sc=S-1: go to DONE.
- DONE: exactly one cycle. done=1, eoc set (stays 1 until next accepted start or rst), rst_mmm=1, other controls 0. Then → IDLE.
- Latency: start accepted at cycle 0; done at cycle 1+(2+len_reg)·S (en held 1). Example: WIDTH=8, len=10 → cycle 145.
- en=0: state, sc, bc, e_reg and all outputs hold. Each en=0 cycle delays done by exactly one cycle. start is ignored while en=0.
- abort=1 with en=1 in any non-IDLE state: → IDLE next cycle; no done; eoc stays 0.
  - abort in IDLE, including together with start: start ignored.
- start while busy: ignored.
- rst mid-operation: next cycle is IDLE with all outputs and eoc 0. rst overrides en.
- exp_len > EXP_WIDTH: clamped to EXP_WIDTH.
- exp_len=0: EXP phase skipped; PRE → POST directly.

Test Plan:
- Reset: rst=1 for 2 cycles mid-run (in EXP) → next cycle busy=0, done=0, eoc=0, rst_mmm=0, all controls 0.
- Nominal, WIDTH=8, exp_e=10'b0000001011, exp_len=4, start at cycle 0:
  - ld_a at cycles 1, 13, 25, 37, 49, 61.
  - ld_r at cycles 12, 24, …, 72.
  - lock1 during EXP slots = 1, 1, 0, 1.
  - sel1=01 during cycles 13–60; sel1=10 during cycles 61–72.
  - done pulse at cycle 73; eoc=1 from cycle 73 onward.
- Stall: same run with en=0 for cycles 30–34 → all outputs frozen over that window; done at cycle 78.
- Abort: abort=1 at cycle 30 → IDLE at cycle 31 with rst_mmm=0; done never asserts; eoc stays 0. A new start at cycle 40 then completes normally at cycle 113.
- Length boundaries:
  - exp_len=0 → done at cycle 25 with no sel1=01 cycles.
  - exp_len=15 with EXP_WIDTH=10 → clamped; done at cycle 145.
- Parametrisation: WIDTH=16, EXP_WIDTH=17, exp_len=17 → S=20; done at cycle 1+19·20=381. Also check start at cycle 100 (busy) is ignored and start+abort together in IDLE is ignored.
